// File: rtl/fp_flopoco_pkg.sv
// Shared FloPoCo float definitions: exception encodings, word width helper,
// canonical NaN and the window-reduce state encoding.
package fp_flopoco_pkg;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    function automatic int fp_width(input int we, input int wf);
        return we + wf + 3;
    endfunction

    localparam int DEF_WE = 3;
    localparam int DEF_WF = 3;
    localparam int DEF_W  = fp_width(DEF_WE, DEF_WF);

    // Every NaN is reported as exc=11 with all payload bits cleared.
    localparam logic [DEF_W-1:0] CANON_NAN = {EXC_NAN, {(DEF_W-2){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } win_state_t;

endpackage

// File: rtl/fcmplt.sv
// FloPoCo less-than comparator: xlty = (x < y), false if either side is NaN.
// Combinational, zero latency; no flow control.
// Zeros of either sign compare equal; infinities order past all normals.
module fcmplt
    import fp_flopoco_pkg::*;
#(
    parameter  int WE = 3,
    parameter  int WF = 3,
    localparam int W  = WE + WF + 3
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         xlty
);

    localparam int MW = WE + WF;

    // Magnitude key: class (zero/normal/inf) above exp,frac so a plain
    // unsigned compare orders magnitudes across classes.
    function automatic logic [MW+1:0] mag_key(input logic [W-1:0] v);
        logic [1:0] cls;
        cls = 2'b00;
        if (v[W-1 -: 2] == EXC_NORMAL)
            cls = 2'b01;
        else if (v[W-1 -: 2] == EXC_INF)
            cls = 2'b10;
        return {cls, (v[W-1 -: 2] == EXC_NORMAL) ? v[MW-1:0] : {MW{1'b0}}};
    endfunction

    logic            any_nan;
    logic            x_neg;
    logic            y_neg;
    logic [MW+1:0]   x_key;
    logic [MW+1:0]   y_key;

    always_comb begin
        any_nan = (x[W-1 -: 2] == EXC_NAN) || (y[W-1 -: 2] == EXC_NAN);
        x_neg   = x[W-3] && (x[W-1 -: 2] != EXC_ZERO);
        y_neg   = y[W-3] && (y[W-1 -: 2] != EXC_ZERO);
        x_key   = mag_key(x);
        y_key   = mag_key(y);
        xlty    = 1'b0;
        if (!any_nan) begin
            if (x_neg != y_neg)
                xlty = x_neg;
            else if (x_neg)
                xlty = (x_key > y_key);
            else
                xlty = (x_key < y_key);
        end
    end

endmodule

// File: rtl/fmax_window_reduce.sv
// Max/argmax over consecutive windows of N FloPoCo floats, NaN-sticky.
// Latency: result valid the cycle after the Nth accepted element.
// Backpressure: result held until out_ready; in_ready low while a result is held.
module fmax_window_reduce
    import fp_flopoco_pkg::*;
#(
    parameter  int WE   = 3,
    parameter  int WF   = 3,
    parameter  int N    = 4,
    parameter  int IDXW = (N > 1) ? $clog2(N) : 1,
    localparam int W    = WE + WF + 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [IDXW-1:0] out_idx,
    output logic            out_nan
);

    localparam logic [W-1:0]    NAN_W = {EXC_NAN, {(W-2){1'b0}}};
    localparam logic [IDXW-1:0] LAST  = IDXW'(N - 1);

    win_state_t      state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    max_q, max_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            nan_q, nan_d;
    logic            load_out;
    logic            in_nan;
    logic            x_lt_y;

    fcmplt #(.WE(WE), .WF(WF)) u_cmp (
        .x    (max_q),
        .y    (in_data),
        .xlty (x_lt_y)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        idx_d     = idx_q;
        nan_d     = nan_q;
        load_out  = 1'b0;
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
        in_nan    = (in_data[W-1 -: 2] == EXC_NAN);
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (cnt_q == '0) begin
                        // First element opens the window; prior NaN history is dropped.
                        max_d = in_nan ? NAN_W : in_data;
                        idx_d = '0;
                        nan_d = in_nan;
                    end else if (in_nan && !nan_q) begin
                        max_d = NAN_W;
                        idx_d = cnt_q;
                        nan_d = 1'b1;
                    end else if (x_lt_y && !nan_q) begin
                        max_d = in_data;
                        idx_d = cnt_q;
                    end
                    if (cnt_q == LAST) begin
                        cnt_d    = '0;
                        state_d  = HOLD;
                        load_out = 1'b1;
                    end else begin
                        cnt_d = cnt_q + IDXW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready)
                    state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            nan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            nan_q   <= nan_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_idx  <= '0;
            out_nan  <= 1'b0;
        end else if (load_out) begin
            out_data <= max_d;
            out_idx  <= idx_d;
            out_nan  <= nan_d;
        end
    end

endmodule

// File: tb/tb_fmax_window_reduce.sv
// Directed bench for fmax_window_reduce with N=4, N=1 and N=5 instances.
module tb_fmax_window_reduce;
    import fp_flopoco_pkg::*;

    localparam logic [8:0] P1   = 9'b01_0_011_000;
    localparam logic [8:0] P2   = 9'b01_0_100_000;
    localparam logic [8:0] P3   = 9'b01_0_100_100;
    localparam logic [8:0] P35  = 9'b01_0_100_110;
    localparam logic [8:0] P4   = 9'b01_0_101_000;
    localparam logic [8:0] P5   = 9'b01_0_101_010;
    localparam logic [8:0] M1   = 9'b01_1_011_000;
    localparam logic [8:0] M2   = 9'b01_1_100_000;
    localparam logic [8:0] M3   = 9'b01_1_100_100;
    localparam logic [8:0] PZ   = 9'b00_0_000_000;
    localparam logic [8:0] MZ   = 9'b00_1_000_000;
    localparam logic [8:0] PINF = 9'b10_0_000_000;
    localparam logic [8:0] MINF = 9'b10_1_000_000;
    localparam logic [8:0] QNAN = 9'b11_0_101_011;

    logic clk = 1'b0;
    logic rst;
    logic [8:0] din;
    logic iv4, iv1, iv5, or4, or1, or5;
    logic rdy4, rdy1, rdy5, ov4, ov1, ov5, on4, on1, on5;
    logic [8:0] od4, od1, od5;
    logic [1:0] ox4;
    logic [0:0] ox1;
    logic [2:0] ox5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fmax_window_reduce #(.WE(3), .WF(3), .N(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .in_data(din),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_idx(ox4), .out_nan(on4));
    fmax_window_reduce #(.WE(3), .WF(3), .N(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .in_data(din),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_idx(ox1), .out_nan(on1));
    fmax_window_reduce #(.WE(3), .WF(3), .N(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(rdy5), .in_data(din),
        .out_valid(ov5), .out_ready(or5), .out_data(od5), .out_idx(ox5), .out_nan(on5));

    typedef struct {
        logic [8:0] e [4];
        logic [8:0] xd;
        logic [1:0] xi;
        logic       xn;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic sel_rdy(input int s);
        case (s)
            1:       return rdy1;
            5:       return rdy5;
            default: return rdy4;
        endcase
    endfunction

    task automatic set_iv(input int s, input logic v);
        case (s)
            1:       iv1 = v;
            5:       iv5 = v;
            default: iv4 = v;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input int s, input logic [8:0] d);
        int t = 0;
        while (!sel_rdy(s) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!sel_rdy(s)) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout dut%0d: in_ready got 0 expected 1", s);
            return;
        end
        din = d;
        set_iv(s, 1'b1);
        @(negedge clk);
        set_iv(s, 1'b0);
    endtask

    task automatic set_row(input int i, input logic [8:0] a, input logic [8:0] b,
                           input logic [8:0] c, input logic [8:0] d,
                           input logic [8:0] xd, input logic [1:0] xi, input logic xn);
        tbl[i].e[0] = a;
        tbl[i].e[1] = b;
        tbl[i].e[2] = c;
        tbl[i].e[3] = d;
        tbl[i].xd   = xd;
        tbl[i].xi   = xi;
        tbl[i].xn   = xn;
    endtask

    function automatic real fval(input logic [8:0] d);
        real m;
        int  e;
        if (d[8:7] == EXC_ZERO)
            m = 0.0;
        else if (d[8:7] == EXC_INF)
            m = 1.0e30;
        else begin
            m = 1.0 + real'(d[2:0]) / 8.0;
            e = int'(d[5:3]) - 3;
            if (e > 0) repeat (e) m = m * 2.0;
            else repeat (-e) m = m / 2.0;
        end
        return d[6] ? -m : m;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        din = '0;
        iv4 = 0; iv1 = 0; iv5 = 0;
        or4 = 1; or1 = 1; or5 = 1;

        set_row(0, P1,   P35,  M2,   P2,   P35,       2'd1, 1'b0);
        set_row(1, P2,   P2,   MZ,   PZ,   P2,        2'd0, 1'b0);
        set_row(2, MZ,   PZ,   M1,   M3,   MZ,        2'd0, 1'b0);
        set_row(3, MINF, P5,   PINF, QNAN, CANON_NAN, 2'd3, 1'b1);
        set_row(4, P1,   P2,   P3,   P4,   P4,        2'd3, 1'b0);
        set_row(5, MINF, MINF, M1,   M3,   M1,        2'd2, 1'b0);
        set_row(6, QNAN, PINF, QNAN, P1,   CANON_NAN, 2'd0, 1'b1);
        set_row(7, PZ,   MINF, MZ,   PZ,   PZ,        2'd0, 1'b0);
        set_row(8, P2,   P35,  P3,   P35,  P35,       2'd1, 1'b0);

        #1;
        check("rst_ov4", ov4, 0);
        check("rst_od4", od4, 0);
        check("rst_ox4", ox4, 0);
        check("rst_on4", on4, 0);
        check("rst_rdy4", rdy4, 1);
        check("rst_ov1", ov1, 0);
        check("rst_ov5", ov5, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_rdy4", rdy4, 1);

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3) check($sformatf("v%0d_pre_valid", i), ov4, 0);
                push(4, tbl[i].e[k]);
            end
            check($sformatf("v%0d_latency", i), ov4, 1);
            check($sformatf("v%0d_data", i), od4, tbl[i].xd);
            check($sformatf("v%0d_idx", i), ox4, tbl[i].xi);
            check($sformatf("v%0d_nan", i), on4, tbl[i].xn);
            @(negedge clk);
            check($sformatf("v%0d_one_cycle", i), ov4, 0);
        end

        // Backpressure: held result, blocked input even with in_valid asserted.
        or4 = 1'b0;
        push(4, P1); push(4, P2); push(4, P3); push(4, P4);
        din = PINF;
        iv4 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", ov4, 1);
            check("bp_ready", rdy4, 0);
            check("bp_data", od4, P4);
            check("bp_idx", ox4, 3);
            check("bp_cnt", dut4.cnt_q, 0);
            @(negedge clk);
        end
        or4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        check("hs_valid", ov4, 0);
        check("hs_ready", rdy4, 1);
        check("hs_cnt", dut4.cnt_q, 0);
        check("hs_data", od4, P4);

        // N=1: every element is its own window.
        push(1, P35);
        check("n1_valid", ov1, 1);
        check("n1_data", od1, P35);
        check("n1_idx", ox1, 0);
        check("n1_nan", on1, 0);
        @(negedge clk);
        check("n1_drop", ov1, 0);
        push(1, QNAN);
        check("n1_nan_data", od1, CANON_NAN);
        check("n1_nan_flag", on1, 1);
        push(1, MINF);
        check("n1_minf_data", od1, MINF);
        check("n1_minf_nan", on1, 0);

        // N=5: wrap at a non-power-of-two count.
        push(5, P1); push(5, P2); push(5, P5); push(5, P3);
        check("n5_no_wrap_at4", ov5, 0);
        push(5, P4);
        check("n5_valid", ov5, 1);
        check("n5_data", od5, P5);
        check("n5_idx", ox5, 2);

        // Gapped input against a reference max model, with cnt tracking.
        for (int w = 0; w < 4; w++) begin
            logic [8:0] e [4];
            int bi;
            for (int k = 0; k < 4; k++) begin
                e[k] = {2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                        3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            end
            bi = 0;
            for (int k = 1; k < 4; k++)
                if (fval(e[k]) > fval(e[bi])) bi = k;
            for (int k = 0; k < 4; k++) begin
                int gap;
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
                check("gap_cnt_hold", dut4.cnt_q, k);
                push(4, e[k]);
                if (k < 3) begin
                    check("gap_cnt_next", dut4.cnt_q, k + 1);
                    check("gap_no_valid", ov4, 0);
                end
            end
            check("gap_valid", ov4, 1);
            check("gap_data", od4, e[bi]);
            check("gap_idx", ox4, bi);
            check("gap_nan", on4, 0);
        end

        // Reset mid-window on all three instances.
        @(negedge clk);
        push(5, P5); push(5, PINF);
        push(1, P3); push(1, P4);
        push(4, P5); push(4, PINF);
        check("pre_rst_cnt4", dut4.cnt_q, 2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_od4", od4, 0);
        check("arst_ox4", ox4, 0);
        check("arst_on4", on4, 0);
        check("arst_ov4", ov4, 0);
        check("arst_cnt4", dut4.cnt_q, 0);
        check("arst_od1", od1, 0);
        check("arst_od5", od5, 0);
        check("arst_cnt5", dut5.cnt_q, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(4, P1); push(4, P2);
        check("fresh4_mid", ov4, 0);
        push(4, P1); push(4, P3);
        check("fresh4_valid", ov4, 1);
        check("fresh4_data", od4, P3);
        check("fresh4_idx", ox4, 3);
        push(1, M3);
        check("fresh1_data", od1, M3);
        check("fresh1_idx", ox1, 0);
        push(5, P1); push(5, P1); push(5, P4); push(5, P4);
        check("fresh5_mid", ov5, 0);
        push(5, P2);
        check("fresh5_valid", ov5, 1);
        check("fresh5_data", od5, P4);
        check("fresh5_idx", ox5, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
